// File: rtl/scan_test_sequencer.sv
// Tester-side scan driver: loads a PPI vector, applies PI with one capture clock, unloads PPO.
// Response latency is 2*CHAIN_LEN+1 edges after accept; one vector in flight, held in RESP until rsp_ready.
module scan_test_sequencer #(
    parameter int CHAIN_LEN = 2,
    parameter int PI_W      = 1,
    parameter int PO_W      = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 vec_valid,
    output logic                 vec_ready,
    input  logic [PI_W-1:0]      vec_pi,
    input  logic [CHAIN_LEN-1:0] vec_ppi,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [CHAIN_LEN-1:0] rsp_ppo,
    output logic [PO_W-1:0]      rsp_po,
    output logic                 scan_en,
    output logic                 scan_in,
    input  logic                 scan_out,
    output logic [PI_W-1:0]      pi,
    input  logic [PO_W-1:0]      po
);

    localparam int            CW   = $clog2(CHAIN_LEN + 1);
    localparam logic [CW-1:0] LAST = CW'(CHAIN_LEN - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT_IN,
        ST_CAPTURE,
        ST_SHIFT_OUT,
        ST_RESP
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [CW-1:0]          cnt;
    logic [CW-1:0]          cnt_next;
    logic                   accept;
    logic [CHAIN_LEN-1:0]   ppi_sr;
    logic [CHAIN_LEN-1:0]   ppi_shifted;
    logic [CHAIN_LEN-1:0]   ppo_shifted;

    // LSB leaves first on the way in; first sample out ends up in bit 0.
    generate
        if (CHAIN_LEN == 1) begin : g_single
            assign ppi_shifted = 1'b0;
            assign ppo_shifted = scan_out;
        end else begin : g_multi
            assign ppi_shifted = {1'b0, ppi_sr[CHAIN_LEN-1:1]};
            assign ppo_shifted = {scan_out, rsp_ppo[CHAIN_LEN-1:1]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        vec_ready  = 1'b0;
        rsp_valid  = 1'b0;
        scan_en    = 1'b0;
        scan_in    = 1'b0;
        accept     = 1'b0;
        case (state)
            ST_IDLE: begin
                vec_ready = rst_n;
                if (vec_valid) begin
                    accept     = 1'b1;
                    state_next = ST_SHIFT_IN;
                    cnt_next   = '0;
                end
            end
            ST_SHIFT_IN: begin
                scan_en = 1'b1;
                scan_in = ppi_sr[0];
                if (cnt == LAST) begin
                    state_next = ST_CAPTURE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + ONE;
                end
            end
            ST_CAPTURE: begin
                state_next = ST_SHIFT_OUT;
                cnt_next   = '0;
            end
            ST_SHIFT_OUT: begin
                scan_en = 1'b1;
                if (cnt == LAST) begin
                    state_next = ST_RESP;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + ONE;
                end
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // pi keeps driving the last accepted vector until the next accept.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pi      <= '0;
            ppi_sr  <= '0;
            rsp_ppo <= '0;
            rsp_po  <= '0;
        end else begin
            if (accept) begin
                pi     <= vec_pi;
                ppi_sr <= vec_ppi;
            end
            if (state == ST_SHIFT_IN) begin
                ppi_sr <= ppi_shifted;
            end
            if (state == ST_CAPTURE) begin
                rsp_po <= po;
            end
            if (state == ST_SHIFT_OUT) begin
                rsp_ppo <= ppo_shifted;
            end
        end
    end

endmodule
